// File: rtl/kpg_prefix_seq_if.sv
// kpg_prefix_seq_if: operand/result handshake bundle for the sequential prefix adder.
interface kpg_prefix_seq_if #(parameter int WIDTH = 16);
   logic             in_valid, in_ready, cin;
   logic [WIDTH-1:0] a, b, sum;
   logic             out_valid, out_ready, cout, busy;
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, busy);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, busy);
endinterface

// File: rtl/kpg_prefix_seq.sv
// kpg_prefix_seq: multi-cycle Kogge-Stone adder, one KPG prefix stage per clock.
module kpg_prefix_seq #(parameter int WIDTH = 16) (
   input logic clk,
   input logic rst,
   kpg_prefix_seq_if.slave bus
);
   localparam int STAGES = $clog2(WIDTH + 1);
   localparam int SW = (STAGES > 1) ? $clog2(STAGES + 1) : 1;
   localparam logic [1:0] K = 2'b00, P = 2'b01, G = 2'b10;
   typedef enum logic [1:0] {IDLE, PREFIX, DONE} state_t;
   state_t state;
   logic [SW-1:0] s;
   logic [WIDTH-1:0] ar, br;
   logic [WIDTH:0][1:0] v, v_init, v_new;
   logic [WIDTH:0] carry;
   always_comb begin
      v_init[0] = bus.cin ? G : K;
      for (int i = 0; i < WIDTH; i++) v_init[i+1] = {bus.a[i] & bus.b[i], bus.a[i] ^ bus.b[i]};
   end
   // Stage distance is unrolled per stage so every index stays constant.
   always_comb begin
      v_new = v;
      for (int j = 0; j < STAGES; j++)
         for (int i = 1 << j; i <= WIDTH; i++)
            if (s == SW'(j)) v_new[i] = (v[i] == P) ? v[i-(1<<j)] : v[i];
      for (int i = 0; i <= WIDTH; i++) carry[i] = (v_new[i] == G);
   end
   always_ff @(posedge clk)
      if (rst) begin
         state    <= IDLE;
         s        <= '0;
         v        <= '0;
         ar       <= '0;
         br       <= '0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
      end else
         case (state)
            IDLE: if (bus.in_valid) begin
               ar    <= bus.a;
               br    <= bus.b;
               v     <= v_init;
               s     <= '0;
               state <= PREFIX;
            end
            PREFIX: begin
               v <= v_new;
               s <= s + 1'b1;
               if (s == SW'(STAGES - 1)) begin
                  bus.sum  <= ar ^ br ^ carry[WIDTH-1:0];
                  bus.cout <= carry[WIDTH];
                  state    <= DONE;
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
   assign bus.in_ready  = (state == IDLE) & ~rst;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
endmodule
